// File: rtl/led_blink_ctrl_if.sv
// led_blink_ctrl_if: configuration strobe and LED status bundle for the LED sequencer
interface led_blink_ctrl_if #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 32,
   parameter int BURST_W = 8,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic               cfg_we_i;
   logic [CH_W-1:0]    cfg_ch_i;
   logic [1:0]         cfg_mode_i;
   logic [CNT_W-1:0]   cfg_half_period_i;
   logic [BURST_W-1:0] cfg_burst_i;
   logic [N_CH-1:0]    led_o;
   logic [N_CH-1:0]    busy_o;
   logic [N_CH-1:0]    done_o;
   modport master (
      output cfg_we_i, cfg_ch_i, cfg_mode_i, cfg_half_period_i, cfg_burst_i,
      input  led_o, busy_o, done_o
   );
   modport slave (
      input  cfg_we_i, cfg_ch_i, cfg_mode_i, cfg_half_period_i, cfg_burst_i,
      output led_o, busy_o, done_o
   );
endinterface

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED sequencer with OFF/ON/BLINK/BURST modes per channel
module led_blink_ctrl #(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 32,
   parameter int DEF_HALF = 500000,
   parameter int BURST_W  = 8
) (
   input logic               clk,
   input logic               rst,
   led_blink_ctrl_if.slave   bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [1:0] M_OFF   = 2'd0;
   localparam logic [1:0] M_ON    = 2'd1;
   localparam logic [1:0] M_BLINK = 2'd2;
   localparam logic [1:0] M_BURST = 2'd3;
   logic [N_CH-1:0] led_v, busy_v, done_v;
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [1:0]         mode_q, mode_d;
      logic [CNT_W-1:0]   half_q, half_d, cnt_q, cnt_d, heff;
      logic [BURST_W:0]   tog_q, tog_d;
      logic               led_q, led_d, busy_q, busy_d, done_q, done_d;
      logic               wr, hit;
      assign wr   = bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(g));
      assign heff = (half_q == '0) ? CNT_W'(1) : half_q;
      assign hit  = cnt_q == heff - 1'b1;
      // next state: a write always wins, then burst completion, then counting
      always_comb begin
         mode_d = mode_q;
         half_d = half_q;
         cnt_d  = cnt_q;
         tog_d  = tog_q;
         led_d  = led_q;
         busy_d = busy_q;
         done_d = 1'b0;
         if (wr) begin
            mode_d = bus.cfg_mode_i;
            half_d = bus.cfg_half_period_i;
            cnt_d  = '0;
            tog_d  = {bus.cfg_burst_i, 1'b0};
            led_d  = bus.cfg_mode_i == M_ON;
            busy_d = (bus.cfg_mode_i == M_BLINK) || (bus.cfg_mode_i == M_BURST && bus.cfg_burst_i != '0);
         end else if (mode_q == M_BURST && tog_q == '0) begin
            mode_d = M_OFF;
            led_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else if (mode_q == M_BLINK || mode_q == M_BURST) begin
            cnt_d = hit ? '0 : cnt_q + 1'b1;
            if (hit) begin
               led_d = ~led_q;
               if (mode_q == M_BURST) begin
                  tog_d = tog_q - 1'b1;
                  if (tog_q == (BURST_W+1)'(1)) begin
                     mode_d = M_OFF;
                     cnt_d  = '0;
                     led_d  = 1'b0;
                     busy_d = 1'b0;
                     done_d = 1'b1;
                  end
               end
            end
         end
      end
      // channel state registers, asynchronously cleared to idle defaults
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            mode_q <= M_OFF;
            half_q <= CNT_W'(DEF_HALF);
            cnt_q  <= '0;
            tog_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            tog_q  <= tog_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
         end
      end
      assign led_v[g]  = led_q;
      assign busy_v[g] = busy_q;
      assign done_v[g] = done_q;
   end
   assign bus.led_o  = led_v;
   assign bus.busy_o = busy_v;
   assign bus.done_o = done_v;
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed self-checking bench for the LED sequencer
module tb_led_blink_ctrl;
   localparam int N_CH = 5;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int n_chk = 0;
   int n_err = 0;
   led_blink_ctrl_if #(.N_CH(N_CH), .CNT_W(32), .BURST_W(8)) b ();
   led_blink_ctrl #(.N_CH(N_CH), .CNT_W(32), .DEF_HALF(4), .BURST_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(b.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic wr(input int ch, input int mode, input int half, input int burst);
      b.cfg_we_i          = 1'b1;
      b.cfg_ch_i          = 3'(ch);
      b.cfg_mode_i        = 2'(mode);
      b.cfg_half_period_i = 32'(half);
      b.cfg_burst_i       = 8'(burst);
      @(negedge clk);
      b.cfg_we_i = 1'b0;
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      int rises, bad;
      logic prev;
      b.cfg_we_i = 1'b0;
      b.cfg_ch_i = '0;
      b.cfg_mode_i = '0;
      b.cfg_half_period_i = '0;
      b.cfg_burst_i = '0;
      step(3);
      rst = 1'b1;
      step(1);
      chk("rst_led", 32'(b.led_o), 0);
      chk("rst_busy", 32'(b.busy_o), 0);
      chk("rst_done", 32'(b.done_o), 0);
      // BLINK ch0 half=5
      wr(0, 2, 5, 0);
      chk("blink_led0", 32'(b.led_o[0]), 0);
      chk("blink_busy0", 32'(b.busy_o[0]), 1);
      rises = 0;
      bad = 0;
      prev = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step(1);
         if (b.led_o[0] !== 1'((n / 5) % 2)) bad++;
         if (b.busy_o[0] !== 1'b1) bad++;
         if (b.led_o[0] && !prev) rises++;
         prev = b.led_o[0];
      end
      chk("blink_wave", 32'(bad), 0);
      chk("blink_rises", 32'(rises), 4);
      wr(0, 0, 5, 0);
      chk("off_led0", 32'(b.led_o[0]), 0);
      chk("off_busy0", 32'(b.busy_o[0]), 0);
      // BURST ch1 half=3 burst=2
      wr(1, 3, 3, 2);
      chk("burst_led1", 32'(b.led_o[1]), 0);
      chk("burst_busy1", 32'(b.busy_o[1]), 1);
      for (int n = 1; n <= 20; n++) begin
         step(1);
         chk($sformatf("burst_led1@%0d", n), 32'(b.led_o[1]), 32'((n >= 3 && n < 6) || (n >= 9 && n < 12)));
         chk($sformatf("burst_done1@%0d", n), 32'(b.done_o[1]), 32'(n == 12));
         chk($sformatf("burst_busy1@%0d", n), 32'(b.busy_o[1]), 32'(n < 12));
      end
      // half=0 blink on ch2 toggles every cycle
      wr(2, 2, 0, 0);
      chk("h0_led2", 32'(b.led_o[2]), 0);
      for (int n = 1; n <= 6; n++) begin
         step(1);
         chk($sformatf("h0_led2@%0d", n), 32'(b.led_o[2]), 32'(n % 2));
      end
      // BURST with burst=0: done at write edge +1
      wr(2, 3, 3, 0);
      chk("b0_led2", 32'(b.led_o[2]), 0);
      chk("b0_busy2", 32'(b.busy_o[2]), 0);
      chk("b0_done2_k", 32'(b.done_o[2]), 0);
      step(1);
      chk("b0_done2_k1", 32'(b.done_o[2]), 1);
      chk("b0_led2_k1", 32'(b.led_o[2]), 0);
      step(1);
      chk("b0_done2_k2", 32'(b.done_o[2]), 0);
      // out-of-range channel index is ignored
      wr(0, 1, 5, 0);
      chk("on_led", 32'(b.led_o), 32'h01);
      wr(N_CH, 0, 5, 0);
      chk("badch_led", 32'(b.led_o), 32'h01);
      chk("badch_busy", 32'(b.busy_o), 0);
      wr(7, 2, 1, 0);
      step(3);
      chk("badch7_led", 32'(b.led_o), 32'h01);
      chk("badch7_busy", 32'(b.busy_o), 0);
      wr(0, 0, 5, 0);
      // preemption: BURST ch2 burst=5 half=4, ON after 3rd toggle
      wr(2, 3, 4, 5);
      step(12);
      chk("pre_led2_t3", 32'(b.led_o[2]), 1);
      chk("pre_busy2_t3", 32'(b.busy_o[2]), 1);
      wr(2, 1, 4, 0);
      chk("pre_led2", 32'(b.led_o[2]), 1);
      chk("pre_busy2", 32'(b.busy_o[2]), 0);
      bad = 0;
      for (int n = 0; n < 40; n++) begin
         step(1);
         if (b.done_o[2] !== 1'b0 || b.led_o[2] !== 1'b1) bad++;
      end
      chk("pre_hold", 32'(bad), 0);
      // write landing on the terminal-toggle edge
      wr(2, 3, 2, 1);
      step(2);
      chk("term_led2_on", 32'(b.led_o[2]), 1);
      step(1);
      wr(2, 2, 3, 0);
      chk("term_done2", 32'(b.done_o[2]), 0);
      chk("term_busy2", 32'(b.busy_o[2]), 1);
      chk("term_led2", 32'(b.led_o[2]), 0);
      bad = 0;
      for (int n = 0; n < 10; n++) begin
         step(1);
         if (b.done_o[2] !== 1'b0) bad++;
      end
      chk("term_nodone", 32'(bad), 0);
      wr(2, 0, 1, 0);
      // independence: ch0 half=2 keeps its phase while ch3 is rewritten
      wr(0, 2, 2, 0);
      wr(3, 2, 7, 0);
      bad = 0;
      for (int n = 2; n <= 101; n++) begin
         if (n % 9 == 3) wr(3, 2, 7 + n % 4, 0);
         else step(1);
         if (b.led_o[0] !== 1'((n / 2) % 2)) bad++;
      end
      chk("indep_ch0", 32'(bad), 0);
      chk("indep_busy3", 32'(b.busy_o[3]), 1);
      // asynchronous reset mid-blink
      step(1);
      chk("arst_pre_led0", 32'(b.led_o[0]), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_led", 32'(b.led_o), 0);
      chk("arst_busy", 32'(b.busy_o), 0);
      chk("arst_done", 32'(b.done_o), 0);
      step(3);
      rst = 1'b1;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         step(1);
         if (b.led_o !== '0) bad++;
      end
      chk("arst_hold", 32'(bad), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Multi-channel LED sequencer that generalises the single fixed-rate toggle counter.
- Each of N_CH channels has a runtime-programmable half-period and a mode: OFF, ON, continuous BLINK, or BURST (a counted number of blinks, then stop).
- Sits between board-level control logic (switches, debug registers) and the LED pins.
- Configured one channel at a time through a simple write strobe.

Parameters:
- N_CH, 4, number of independent LED channels (1..16).
- CNT_W, 32, width of the half-period counter and the cfg_half_period field.
- DEF_HALF, 500000, half-period loaded into every channel at reset.
- BURST_W, 8, width of the burst blink-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  configuration write strobe, sampled on rising clk.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_half_period  in  CNT_W  cycles per LED half-period.
- cfg_burst  in  BURST_W  number of on-pulses in BURST mode.
- led  out  N_CH  LED drive, one bit per channel, registered.
- busy  out  N_CH  high while the channel is in BLINK, or in BURST with blinks remaining.
- done  out  N_CH  one-cycle pulse when a BURST completes.

Behaviour:
- Reset (rst=0, asynchronous), every channel:
  - mode=OFF, half=DEF_HALF, cnt=0, remaining toggles=0.
  - led=0, busy=0, done=0.
- Per-channel state: mode[1:0], half[CNT_W], cnt[CNT_W], tog_left[BURST_W+1].
- Effective half-period heff = max(half, 1). A value of 0 is treated as 1, so it never stalls.
- Config write, when cfg_we=1 at edge k and cfg_ch < N_CH:
  - The channel loads mode and half, clears cnt, and sets tog_left = 2*cfg_burst (BURST_W+1 bits, no overflow).
  - After edge k: led=1 if ON, otherwise led=0.
  - After edge k: busy=1 for BLINK, and for BURST with cfg_burst>0; busy=0 otherwise.
  - done=0 after edge k.
- cfg_ch >= N_CH: the write is ignored and no state changes.
- A write preempts any operation in progress on that channel immediately; there is no pending-completion pulse.
- OFF and ON modes: cnt holds at 0; led holds 0 or 1 respectively.
- BLINK mode:
  - cnt increments every cycle.
  - When cnt == heff-1, cnt wraps to 0 and led toggles.
  - First toggle (0→1) occurs heff cycles after the write edge, so the period is 2*heff cycles.
- BURST mode: counts and toggles the same way as BLINK, and each toggle decrements tog_left.
  - When the toggle that brings tog_left to 0 occurs, that same edge sets led=0, busy=0, done=1, and mode becomes OFF.
  - done returns to 0 on the next edge.
  - BURST with cfg_burst=0: mode becomes OFF, and done pulses one cycle after the write edge (edge k+1). led stays 0.
- Simultaneous write and terminal toggle on the same channel: the write wins and no done pulse is produced.
- Channels are fully independent. Writes to one channel never disturb the cnt or led of another.
- All outputs are registered. There is no combinational path from the cfg_* inputs to led, busy or done.

Test Plan:
- Reset: rst low mid-blink → led=0, busy=0, done=0 on all channels asynchronously (no clock edge needed). Hold rst low 3 cycles, release, run 20 cycles → led stays 0.
- BLINK: write ch0, mode=2, half=5 → led0 rises 5 cycles after the write edge, then toggles every 5 cycles; 4 rising edges in 40 cycles; busy0=1 throughout.
- BURST: write ch1, mode=3, half=3, burst=2 → exactly 2 on-pulses, each 3 cycles high. done1 pulses one cycle at the 4th toggle (12 cycles after the write); then led1=0 and busy1=0 permanently.
- Edge values:
  - half=0 in BLINK → led toggles every cycle.
  - BURST with burst=0 → done pulses at write edge +1, led never high.
  - Write with cfg_ch=N_CH → no channel changes.
- Preemption: ch2 in BURST (burst=5, half=4), write ON after the 3rd toggle → led2=1 immediately, busy2=0, done2 never pulses. Write landing on the terminal-toggle cycle → no done pulse.
- Independence: ch0 BLINK half=2 while ch3 BLINK half=7. Rewrite ch3 repeatedly → ch0 phase and period unchanged (toggle every 2 cycles, checked over 100 cycles).
